// File: rtl/control_sequencer_pkg.sv
// Shared types for the JZJCoreF control path: sequencer state, the
// per-unit mode encodings the sequencer drives, the one-hot rd source
// select lines, the instruction classes produced by the opcode decoder,
// and the RV32I major opcodes.
package control_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_EXECUTE,
    ST_WAIT,
    ST_COMMIT_MEM,
    ST_HALTED
  } control_state_t;

  typedef enum logic [1:0] {
    MEM_NOP           = 2'd0,
    MEM_LOAD          = 2'd1,
    MEM_STORE_PRELOAD = 2'd2,
    MEM_STORE         = 2'd3
  } memory_mode_t;

  typedef enum logic {
    ADDR_CURRENT_PC = 1'b0,
    ADDR_NEXT_PC    = 1'b1
  } inst_addr_source_t;

  typedef enum logic [1:0] {
    BR_INCREMENT = 2'd0,
    BR_JAL       = 2'd1,
    BR_JALR      = 2'd2,
    BR_BRANCH    = 2'd3
  } branch_alu_mode_t;

  typedef enum logic {
    ALU_REGISTER = 1'b0,
    ALU_OP_IMM   = 1'b1
  } alu_mode_t;

  typedef enum logic {
    IMM_LUI   = 1'b0,
    IMM_AUIPC = 1'b1
  } imm_former_mode_t;

  typedef enum logic [1:0] {
    CLASS_SIMPLE = 2'd0,
    CLASS_LOAD   = 2'd1,
    CLASS_STORE  = 2'd2,
    CLASS_HALT   = 2'd3
  } instr_class_t;

  // rd source select lines: one-hot, all-zero when nothing drives rd
  localparam logic [3:0] RD_SRC_NONE   = 4'b0000;
  localparam logic [3:0] RD_SRC_IMM    = 4'b0001;
  localparam logic [3:0] RD_SRC_BRANCH = 4'b0010;
  localparam logic [3:0] RD_SRC_ALU    = 4'b0100;
  localparam logic [3:0] RD_SRC_MEM    = 4'b1000;

  localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
  localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
  localparam logic [6:0] OPCODE_OP       = 7'b0110011;
  localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
  localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
  localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
  localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;

endpackage

// File: rtl/control_opcode_decoder.sv
// Combinational decode of the latched instruction register.
// Ports:
//   ir          in   32  latched instruction
//   legal       out  1   encoding is supported
//   writes_rd   out  1   instruction commits a value to rd
//   op_class    out  2   instr_class_t: SIMPLE / LOAD / STORE / HALT
//   branch_mode out  2   branch_alu_mode_t for the EXECUTE cycle
//   alu_mode    out  1   alu_mode_t for the EXECUTE cycle
//   imm_mode    out  1   imm_former_mode_t for the EXECUTE cycle
//   rd_select   out  4   one-hot rd source, zero unless writes_rd
// Illegal encodings come out as a SIMPLE class with no rd write and all
// modes at their defaults, so they retire as a NOP if the sequencer does
// not halt on them.
module control_opcode_decoder
  import control_sequencer_pkg::*;
(
  input  logic [31:0] ir,
  output logic        legal,
  output logic        writes_rd,
  output logic [1:0]  op_class,
  output logic [1:0]  branch_mode,
  output logic        alu_mode,
  output logic        imm_mode,
  output logic [3:0]  rd_select
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign funct7 = ir[31:25];

  // NOTE: every output gets a default before the case so no path through
  // the decode leaves a variable unassigned, which would infer a latch.
  always_comb begin
    legal       = 1'b1;
    writes_rd   = 1'b0;
    op_class    = CLASS_SIMPLE;
    branch_mode = BR_INCREMENT;
    alu_mode    = ALU_REGISTER;
    imm_mode    = IMM_LUI;
    rd_select   = RD_SRC_NONE;
    case (opcode)
      OPCODE_LUI: begin
        writes_rd = 1'b1;
        rd_select = RD_SRC_IMM;
      end
      OPCODE_AUIPC: begin
        imm_mode  = IMM_AUIPC;
        writes_rd = 1'b1;
        rd_select = RD_SRC_IMM;
      end
      OPCODE_JAL: begin
        branch_mode = BR_JAL;
        writes_rd   = 1'b1;
        rd_select   = RD_SRC_BRANCH;
      end
      OPCODE_JALR: begin
        branch_mode = BR_JALR;
        writes_rd   = 1'b1;
        rd_select   = RD_SRC_BRANCH;
      end
      OPCODE_BRANCH: branch_mode = BR_BRANCH;
      OPCODE_OP_IMM: begin
        alu_mode  = ALU_OP_IMM;
        writes_rd = 1'b1;
        rd_select = RD_SRC_ALU;
      end
      OPCODE_OP: begin
        if (funct7 == 7'h00 || funct7 == 7'h20) begin
          writes_rd = 1'b1;
          rd_select = RD_SRC_ALU;
        end else begin
          legal = 1'b0;
        end
      end
      OPCODE_MISC_MEM: ;
      OPCODE_LOAD: begin
        if (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7) begin
          legal = 1'b0;
        end else begin
          op_class  = CLASS_LOAD;
          writes_rd = 1'b1;
          rd_select = RD_SRC_MEM;
        end
      end
      OPCODE_STORE: begin
        if (funct3 > 3'd2) legal = 1'b0;
        else               op_class = CLASS_STORE;
      end
      OPCODE_SYSTEM: begin
        // Only ECALL (imm 0x000) and EBREAK (imm 0x001) with zero rs1/funct3/rd
        if (ir[19:7] == 13'd0 && (ir[31:20] == 12'h000 || ir[31:20] == 12'h001))
          op_class = CLASS_HALT;
        else
          legal = 1'b0;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control FSM for the JZJCoreF datapath. Latches each fetched
// instruction, drives per-unit control modes for one instruction at a time,
// produces the rd/PC commit strobes, counts retired instructions and
// reports halt/error.
// Ports:
//   clock, nReset    core clock, asynchronous active-low reset
//   instruction      memory read data, sampled at the end of FETCH
//   memoryError      access fault from memory, sampled in WAIT
//   memoryMode       memory_mode_t
//   instAddrSource   inst_addr_source_t
//   branchALUMode    branch_alu_mode_t
//   aluMode          alu_mode_t
//   immFormerMode    imm_former_mode_t
//   rdSourceSelect   one-hot rd source select, zero without rd write
//   rdWriteEnable    1-cycle rd commit strobe
//   pcWriteEnable    1-cycle PC commit strobe
//   halted           sticky, high once HALTED is reached
//   errorFlag        sticky, high when halted on an error
//   retiredCount     committed instructions, wraps
// All outputs are decoded from registered state and IR only.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int unsigned MEM_LATENCY     = 1,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        clock,
  input  logic        nReset,
  input  logic [31:0] instruction,
  input  logic        memoryError,
  output logic [1:0]  memoryMode,
  output logic        instAddrSource,
  output logic [1:0]  branchALUMode,
  output logic        aluMode,
  output logic        immFormerMode,
  output logic [3:0]  rdSourceSelect,
  output logic        rdWriteEnable,
  output logic        pcWriteEnable,
  output logic        halted,
  output logic        errorFlag,
  output logic [31:0] retiredCount
);

  localparam logic [3:0] WAIT_INIT = 4'(MEM_LATENCY - 1);

  control_state_t state, state_next;
  logic [31:0] ir;
  logic [3:0]  wait_count;
  logic [31:0] retired_count;
  logic        halted_q, error_q;
  logic        start_wait, enter_halt, set_error;

  logic       dec_legal, dec_writes_rd;
  logic [1:0] dec_class, dec_branch_mode;
  logic       dec_alu_mode, dec_imm_mode;
  logic [3:0] dec_rd_select;

  control_opcode_decoder u_decoder (
    .ir          (ir),
    .legal       (dec_legal),
    .writes_rd   (dec_writes_rd),
    .op_class    (dec_class),
    .branch_mode (dec_branch_mode),
    .alu_mode    (dec_alu_mode),
    .imm_mode    (dec_imm_mode),
    .rd_select   (dec_rd_select)
  );

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state         <= ST_FETCH;
      ir            <= 32'd0;
      wait_count    <= 4'd0;
      retired_count <= 32'd0;
      halted_q      <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state <= state_next;
      if (state == ST_FETCH) ir <= instruction;
      if (start_wait)
        wait_count <= WAIT_INIT;
      else if (state == ST_WAIT && wait_count != 4'd0)
        wait_count <= wait_count - 4'd1;
      if (pcWriteEnable) retired_count <= retired_count + 32'd1;
      if (enter_halt) halted_q <= 1'b1;
      if (set_error)  error_q  <= 1'b1;
    end
  end

  always_comb begin
    state_next     = state;
    start_wait     = 1'b0;
    enter_halt     = 1'b0;
    set_error      = 1'b0;
    memoryMode     = MEM_NOP;
    instAddrSource = ADDR_CURRENT_PC;
    branchALUMode  = BR_INCREMENT;
    aluMode        = ALU_REGISTER;
    immFormerMode  = IMM_LUI;
    rdSourceSelect = RD_SRC_NONE;
    rdWriteEnable  = 1'b0;
    pcWriteEnable  = 1'b0;
    unique case (state)
      ST_FETCH: state_next = ST_EXECUTE;
      ST_EXECUTE: begin
        if (!dec_legal && HALT_ON_ILLEGAL) begin
          state_next = ST_HALTED;
          enter_halt = 1'b1;
          set_error  = 1'b1;
        end else begin
          unique case (dec_class)
            CLASS_LOAD: begin
              memoryMode = MEM_LOAD;
              start_wait = 1'b1;
              state_next = ST_WAIT;
            end
            CLASS_STORE: begin
              memoryMode = MEM_STORE_PRELOAD;
              start_wait = 1'b1;
              state_next = ST_WAIT;
            end
            CLASS_HALT: begin
              state_next = ST_HALTED;
              enter_halt = 1'b1;
            end
            default: begin
              // Single-cycle commit; illegal encodings land here as NOPs
              branchALUMode  = dec_branch_mode;
              aluMode        = dec_alu_mode;
              immFormerMode  = dec_imm_mode;
              rdSourceSelect = dec_rd_select;
              rdWriteEnable  = dec_writes_rd;
              pcWriteEnable  = 1'b1;
              instAddrSource = ADDR_NEXT_PC;
              state_next     = ST_FETCH;
            end
          endcase
        end
      end
      ST_WAIT: begin
        memoryMode = (dec_class == CLASS_LOAD) ? MEM_LOAD : MEM_STORE_PRELOAD;
        if (memoryError) begin
          state_next = ST_HALTED;
          enter_halt = 1'b1;
          set_error  = 1'b1;
        end else if (wait_count == 4'd0) begin
          state_next = ST_COMMIT_MEM;
        end
      end
      ST_COMMIT_MEM: begin
        if (dec_class == CLASS_LOAD) begin
          memoryMode     = MEM_LOAD;
          rdSourceSelect = RD_SRC_MEM;
          rdWriteEnable  = 1'b1;
        end else begin
          memoryMode = MEM_STORE;
        end
        pcWriteEnable  = 1'b1;
        instAddrSource = ADDR_NEXT_PC;
        state_next     = ST_FETCH;
      end
      ST_HALTED: state_next = ST_HALTED;
      default:   state_next = ST_FETCH;
    endcase
  end

  assign halted       = halted_q;
  assign errorFlag    = error_q;
  assign retiredCount = retired_count;

endmodule
